fizzbuzz_gen: RTL
=================

# fizzbuzz_gen

Character source that sits directly upstream of the `serial` UART transmitter. On `start`, it walks the integers 1..MAX and emits one text line per integer: "Fizz", "Buzz", "FizzBuzz", or the decimal number with no leading zeros. Every line ends in CR LF. Characters are handed to `serial` one at a time over its `char`/`send`/`busy` handshake, and the block never presents a character while the transmitter is busy.

## Interface
- `MAX`, default 100: last integer emitted, legal range 1..999.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  begins a run when sampled high in IDLE; ignored at all other times.
- `busy`  in  1  from `serial`; high while a character is being shifted out.
- `char`  out  8  ASCII byte to transmit, registered; valid whenever `send` is high.
- `send`  out  1  single-cycle strobe that `serial` uses to latch `char`.
- `active`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  single-cycle pulse after the final LF has finished transmitting.

## Operation
- State on reset: state IDLE, and `char`=0x00, `send`=0, `active`=0, `done`=0. Counters load n=001 (BCD), m3=1, m5=1, pos=0.
- Counters:
  - Three BCD digits d2 d1 d0.
  - m3 counts 0..2 and m5 counts 0..4. Each wraps to 0 on reaching its modulus.
  - fizz = (m3==0); buzz = (m5==0).
- Line positions, 0..12. A position that is not enabled is skipped with no cycle cost, because the next enabled position is computed combinationally.
  - 0-3 "Fizz" (0x46 0x69 0x7A 0x7A), enabled if fizz.
  - 4-7 "Buzz" (0x42 0x75 0x7A 0x7A), enabled if buzz.
  - 8 is d2, 9 is d1, 10 is d0, each sent as 0x30+digit. Enabled only if !fizz && !buzz, with these extra conditions:
    - 8 needs d2≠0.
    - 9 needs d2≠0 or d1≠0.
    - 10 is always enabled under the base condition.
  - 11 CR 0x0D, 12 LF 0x0A, always enabled.
- State machine:
  - IDLE: `start`=1 → EMIT, with pos = first enabled position for n=1.
  - EMIT: if `busy`=0, assert `send` with `char`=byte(pos) and go to GUARD. Otherwise hold in EMIT with `send`=0.
  - GUARD: wait exactly 2 cycles with `busy` ignored, to cover the transmitter's latency in raising `busy`. Then go to WAITB.
  - WAITB: wait for `busy`=0. Then:
    - pos≠12 → EMIT at the next enabled pos.
    - pos==12 and n≠MAX → NEXT.
    - pos==12 and n==MAX → DONE.
  - NEXT: increment n (BCD ripple carry), m3 and m5. Compute the first enabled pos and go to EMIT.
  - DONE: pulse `done`, drop `active`, reload the counters to their reset values, and go to IDLE.
- Reset low at any state: full return to reset values on the next edge. A character already latched by `serial` still completes; this block does not track it.

## Timing
- `start` is sampled high at edge k (IDLE, `busy`=0):
  - `active`=1 after edge k+1.
  - `send`=1 with `char`=0x31 after edge k+1.
- Consecutive sends within one line are spaced by at least 4 cycles: EMIT, 2×GUARD, WAITB. The spacing also includes the transmitter's busy time.
- Between lines there is 1 extra cycle (NEXT).
- `send` is never high on two consecutive cycles, and never high while `busy`=1 is sampled.
- `done` rises exactly 1 cycle after WAITB observes `busy`=0 following the last LF.
- `start` held high through a whole run gives back-to-back runs. There is one IDLE cycle between `done` and the next `active`.

## Structure
- Shared package `fizzbuzz_pkg` holds:
  - ASCII constants: CR, LF, ZERO, and the two 4-byte words.
  - The state encoding: IDLE, EMIT, GUARD, WAITB, NEXT, DONE.
  - The line-position constants.
- One sub-module, `bcd_counter3`: a 3-digit BCD register with an `inc` input, a `load1` input and a digit outputs bus, with decimal carry between digits.
- The top level holds the FSM, the mod-3/mod-5 counters, the position selector and the output registers.

## Test plan
The bench uses a `serial` behavioural model: it latches on `send`, raises `busy` 1 cycle later, and holds it for 20 cycles.
- Reset:
  - Reset held low for 3 cycles with `start`=1 → `send`, `active`, `done`, `char` all 0 throughout, and no send for 10 cycles after release with `start`=0.
  - Reset asserted mid-"Fizz" → outputs 0 on the next edge. A following `start` begins again at "1\r\n".
- MAX=15 run: exactly 73 sends. The captured stream is "1\r\n2\r\nFizz\r\n4\r\nBuzz\r\nFizz\r\n7\r\n8\r\nFizz\r\nBuzz\r\n11\r\nFizz\r\n13\r\n14\r\nFizzBuzz\r\n". Then a single `done` pulse.
- MAX=102 run: the lines for 100, 101 and 102 are "Buzz", "101" and "Fizz". Check that 101 emits bytes 0x31 0x30 0x31, with the internal zero kept and no leading zero on any 1- or 2-digit number.
- Handshake:
  - A model that holds `busy`=1 for 0..50 random cycles → no `send` while `busy`=1, and no two sends fewer than 4 cycles apart.
  - `busy` forced high for 100 cycles before the first character → `send` stays 0 and `char` does not change until `busy` falls.
- `start` pulsed again mid-run → ignored; the stream is identical to a clean run.

Source files
------------

// File: rtl/fizzbuzz_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : fizzbuzz_pkg                                               |
// | Description : Shared constants for the FizzBuzz character source:        |
// |               ASCII bytes, FSM state encoding, line-position indices     |
// |               and helpers that pick the next byte of a line.             |
// | Ports       : none (package)                                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package fizzbuzz_pkg;

   // ASCII bytes
   localparam logic [7:0]  c_cr        = 8'h0D;
   localparam logic [7:0]  c_lf        = 8'h0A;
   localparam logic [7:0]  c_zero      = 8'h30;
   localparam logic [31:0] c_fizz_word = 32'h46697A7A;  // "Fizz"
   localparam logic [31:0] c_buzz_word = 32'h42757A7A;  // "Buzz"

   // FSM state encoding
   localparam int              c_state_w  = 3;
   localparam logic [2:0]      c_st_idle  = 3'd0;
   localparam logic [2:0]      c_st_emit  = 3'd1;
   localparam logic [2:0]      c_st_guard = 3'd2;
   localparam logic [2:0]      c_st_waitb = 3'd3;
   localparam logic [2:0]      c_st_next  = 3'd4;
   localparam logic [2:0]      c_st_done  = 3'd5;

   // Line positions: 0-3 "Fizz", 4-7 "Buzz", 8-10 digits, 11 CR, 12 LF
   localparam logic [3:0] c_pos_fizz = 4'd0;
   localparam logic [3:0] c_pos_buzz = 4'd4;
   localparam logic [3:0] c_pos_d2   = 4'd8;
   localparam logic [3:0] c_pos_d1   = 4'd9;
   localparam logic [3:0] c_pos_d0   = 4'd10;
   localparam logic [3:0] c_pos_cr   = 4'd11;
   localparam logic [3:0] c_pos_lf   = 4'd12;

   // Whether a position contributes a byte to the current line.
   function automatic logic pos_enabled(
      input logic [3:0] pos,
      input logic       fizz,
      input logic       buzz,
      input logic [3:0] d2,
      input logic [3:0] d1
   );
      logic num;
      logic en;
      num = !fizz && !buzz;
      en  = 1'b0;
      if (pos < c_pos_buzz)      en = fizz;
      else if (pos < c_pos_d2)   en = buzz;
      else if (pos == c_pos_d2)  en = num && (d2 != 4'd0);
      else if (pos == c_pos_d1)  en = num && ((d2 != 4'd0) || (d1 != 4'd0));
      else if (pos == c_pos_d0)  en = num;
      else if (pos <= c_pos_lf)  en = 1'b1;
      return en;
   endfunction

   // Lowest enabled position at or above 'from'. LF is always enabled, so
   // the scan always terminates on a valid position.
   function automatic logic [3:0] first_enabled(
      input logic [3:0] from,
      input logic       fizz,
      input logic       buzz,
      input logic [3:0] d2,
      input logic [3:0] d1
   );
      logic [3:0] p;
      p = c_pos_lf;
      // Scan downwards so the smallest qualifying position wins.
      for (int i = 12; i >= 0; i--) begin
         if ((4'(i) >= from) && pos_enabled(4'(i), fizz, buzz, d2, d1)) begin
            p = 4'(i);
         end
      end
      return p;
   endfunction

   function automatic logic [7:0] word_byte(
      input logic [31:0] word,
      input logic [1:0]  idx
   );
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   // ASCII byte for a position; digits = {d2, d1, d0} in BCD.
   function automatic logic [7:0] pos_byte(
      input logic [3:0]  pos,
      input logic [11:0] digits
   );
      logic [7:0] b;
      b = 8'h00;
      if (pos < c_pos_buzz)      b = word_byte(c_fizz_word, pos[1:0]);
      else if (pos < c_pos_d2)   b = word_byte(c_buzz_word, pos[1:0]);
      else if (pos == c_pos_d2)  b = c_zero | {4'h0, digits[11:8]};
      else if (pos == c_pos_d1)  b = c_zero | {4'h0, digits[7:4]};
      else if (pos == c_pos_d0)  b = c_zero | {4'h0, digits[3:0]};
      else if (pos == c_pos_cr)  b = c_cr;
      else if (pos == c_pos_lf)  b = c_lf;
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fizzbuzz_gen_bcd_counter3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bcd_counter3                                               |
// | Description : Three-digit BCD counter with decimal ripple carry.         |
// |               Resets / loads to 001.                                     |
// | Ports       : clk    in   system clock                                   |
// |               rst    in   synchronous active-low reset                   |
// |               inc    in   advance by one                                 |
// |               load1  in   reload 001 (priority over inc)                 |
// |               digits out  {d2, d1, d0}, 4 bits each                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module bcd_counter3
   import fizzbuzz_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        load1,
   output logic [11:0] digits
);

   // w_carry[g] is the increment request arriving at digit g.
   logic [2:0] w_carry;

   assign w_carry[0] = inc;

   for (genvar g = 0; g < 3; g++) begin : g_digit
      localparam logic [3:0] c_init = (g == 0) ? 4'd1 : 4'd0;
      logic [3:0] r_digit;

      always_ff @(posedge clk) begin
         if (!rst || load1) begin
            r_digit <= c_init;
         end else if (w_carry[g]) begin
            r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
         end
      end

      if (g < 2) begin : g_carry
         assign w_carry[g+1] = w_carry[g] && (r_digit == 4'd9);
      end

      assign digits[4*g +: 4] = r_digit;
   end

endmodule
`default_nettype wire

// File: rtl/fizzbuzz_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fizzbuzz_gen                                               |
// | Description : Streams "1".."MAX" FizzBuzz lines (CR LF terminated) one   |
// |               byte at a time to a UART transmitter over char/send/busy.  |
// | Ports       : clk    in   system clock                                   |
// |               rst    in   synchronous active-low reset                   |
// |               start  in   begin a run (sampled in IDLE only)             |
// |               busy   in   transmitter is shifting a byte                 |
// |               char   out  byte to transmit, valid with send              |
// |               send   out  one-cycle strobe latching char                 |
// |               active out  run in progress                                |
// |               done   out  one-cycle pulse after the final LF             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fizzbuzz_gen
   import fizzbuzz_pkg::*;
#(
   parameter int MAX = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       busy,
   output logic [7:0] char,
   output logic       send,
   output logic       active,
   output logic       done
);

   localparam logic [11:0] c_max_bcd = {4'(MAX / 100), 4'((MAX / 10) % 10), 4'(MAX % 10)};

   logic [c_state_w-1:0] r_state;
   logic [c_state_w-1:0] w_state_next;
   logic [3:0]           r_pos;
   logic [3:0]           w_pos_emit;
   logic                 r_guard;
   logic [1:0]           r_m3;
   logic [2:0]           r_m5;
   logic [11:0]          w_digits;
   logic                 w_fizz;
   logic                 w_buzz;
   logic                 w_last;
   logic                 w_inc;
   logic                 w_load1;
   logic [7:0]           r_char;
   logic                 r_send;
   logic                 r_active;
   logic                 r_done;
   logic [7:0]           w_char_d;
   logic                 w_send_d;
   logic                 w_active_d;
   logic                 w_done_d;

   assign w_inc   = (r_state == c_st_next);
   assign w_load1 = (r_state == c_st_done);

   bcd_counter3 u_count (
      .clk    (clk),
      .rst    (rst),
      .inc    (w_inc),
      .load1  (w_load1),
      .digits (w_digits)
   );

   assign w_fizz = (r_m3 == 2'd0);
   assign w_buzz = (r_m5 == 3'd0);
   assign w_last = (w_digits == c_max_bcd);

   // r_pos may point at a disabled position (it is reset to 0 at the start
   // of every line and stepped by one after each byte); the byte actually
   // sent is always the first enabled position at or above it, so skipping
   // costs no cycles and NEXT does not need the post-increment counters.
   assign w_pos_emit = first_enabled(r_pos, w_fizz, w_buzz, w_digits[11:8], w_digits[7:4]);

   // State register, datapath counters and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= c_st_idle;
         r_pos    <= 4'd0;
         r_guard  <= 1'b0;
         r_m3     <= 2'd1;
         r_m5     <= 3'd1;
         r_char   <= 8'h00;
         r_send   <= 1'b0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_char   <= w_char_d;
         r_send   <= w_send_d;
         r_active <= w_active_d;
         r_done   <= w_done_d;
         case (r_state)
            c_st_idle: begin
               r_pos <= 4'd0;
            end
            c_st_emit: begin
               if (!busy) begin
                  r_pos   <= w_pos_emit;
                  r_guard <= 1'b0;
               end
            end
            c_st_guard: begin
               r_guard <= 1'b1;
            end
            c_st_waitb: begin
               if (!busy && (r_pos != c_pos_lf)) begin
                  r_pos <= r_pos + 4'd1;
               end
            end
            c_st_next: begin
               r_pos <= 4'd0;
               r_m3  <= (r_m3 == 2'd2) ? 2'd0 : r_m3 + 2'd1;
               r_m5  <= (r_m5 == 3'd4) ? 3'd0 : r_m5 + 3'd1;
            end
            c_st_done: begin
               r_pos <= 4'd0;
               r_m3  <= 2'd1;
               r_m5  <= 3'd1;
            end
            default: begin
               r_pos <= 4'd0;
            end
         endcase
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle: begin
            if (start) w_state_next = c_st_emit;
         end
         c_st_emit: begin
            if (!busy) w_state_next = c_st_guard;
         end
         c_st_guard: begin
            // busy is ignored here: the transmitter needs time to raise it
            if (r_guard) w_state_next = c_st_waitb;
         end
         c_st_waitb: begin
            if (!busy) begin
               if (r_pos != c_pos_lf) w_state_next = c_st_emit;
               else if (w_last)       w_state_next = c_st_done;
               else                   w_state_next = c_st_next;
            end
         end
         c_st_next: begin
            w_state_next = c_st_emit;
         end
         c_st_done: begin
            w_state_next = c_st_idle;
         end
         default: begin
            w_state_next = c_st_idle;
         end
      endcase
   end

   // Output logic (next values of the output registers)
   always_comb begin
      w_send_d   = (r_state == c_st_emit) && !busy;
      w_char_d   = w_send_d ? pos_byte(w_pos_emit, w_digits) : r_char;
      w_active_d = (r_state == c_st_emit)  || (r_state == c_st_guard) ||
                   (r_state == c_st_waitb) || (r_state == c_st_next);
      w_done_d   = (r_state == c_st_done);
   end

   assign char   = r_char;
   assign send   = r_send;
   assign active = r_active;
   assign done   = r_done;

endmodule
`default_nettype wire
